gon_id_scan_loader: RTL and testbench

- Configures the ID registers of a row or column of GON multicast controllers through their shared scan chain.
- Accepts a stream of ID words on a valid/ready handshake and drives the chain's set_id/id_in head.
- Counts shifts and signals completion once every node holds its intended ID.
- Sits between the layer-config front end and the GON Y/X multicast controller chains; one instance per chain.

---
 rtl/gon_cfg_pkg.sv | 14 +
 rtl/gon_id_scan_loader.sv | 71 +++++++
 tb/tb_gon_id_scan_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gon_cfg_pkg.sv
// rtl/gon_cfg_pkg.sv - shared GON configuration constants and loader state encoding
package gon_cfg_pkg;

  localparam int GON_ID_W       = 4;
  localparam int GON_CHAIN_LEN  = 12;
  localparam int GON_MAX_NODES  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } load_state_e;

endpackage

// File: rtl/gon_id_scan_loader.sv
// rtl/gon_id_scan_loader.sv - streams ID words into a GON multicast controller scan chain
module gon_id_scan_loader
  import gon_cfg_pkg::*;
#(
  parameter int NUM_NODES = GON_CHAIN_LEN,
  parameter int ID_W      = GON_ID_W,
  parameter int CNT_W     = $clog2(NUM_NODES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [ID_W-1:0]  id_data,
  output logic             scan_set_id,
  output logic [ID_W-1:0]  scan_id_out,
  output logic [CNT_W-1:0] load_cnt
);

  load_state_e state, state_nxt;
  logic        accept;
  logic        last_word;
  logic        start_load;

  // abort masks ready so a word offered alongside abort is never consumed
  assign id_ready   = (state == LOAD) && !abort;
  assign accept     = id_valid && id_ready;
  assign last_word  = (load_cnt == CNT_W'(NUM_NODES - 1));
  assign start_load = (state == IDLE) && start && !abort;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_load) state_nxt = LOAD;
      end
      LOAD: begin
        if (abort)                    state_nxt = IDLE;
        else if (accept && last_word) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // shift is registered one cycle behind its accept, so FLUSH carries the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      scan_set_id <= 1'b0;
      scan_id_out <= '0;
      load_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      done        <= (state == FLUSH) && !abort;
      scan_set_id <= accept;
      if (accept) begin
        scan_id_out <= id_data;
        load_cnt    <= load_cnt + CNT_W'(1);
      end else if (start_load) begin
        load_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gon_id_scan_loader.sv
// tb/tb_gon_id_scan_loader.sv - scoreboard bench with behavioural chain model
module tb_gon_id_scan_loader;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, id_valid;
  logic [W-1:0]  id_data;
  logic          busy, done, id_ready, scan_set_id;
  logic [W-1:0]  scan_id_out;
  logic [CW-1:0] load_cnt;

  logic          s1_start, s1_abort, s1_valid;
  logic [W-1:0]  s1_data;
  logic          s1_busy, s1_done, s1_ready, s1_set;
  logic [W-1:0]  s1_out;
  logic [0:0]    s1_cnt;

  gon_id_scan_loader #(.NUM_NODES(N), .ID_W(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .id_valid(id_valid), .id_ready(id_ready), .id_data(id_data),
    .scan_set_id(scan_set_id), .scan_id_out(scan_id_out), .load_cnt(load_cnt)
  );

  gon_id_scan_loader #(.NUM_NODES(1), .ID_W(W)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .abort(s1_abort), .busy(s1_busy), .done(s1_done),
    .id_valid(s1_valid), .id_ready(s1_ready), .id_data(s1_data),
    .scan_set_id(s1_set), .scan_id_out(s1_out), .load_cnt(s1_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] exp_shift[$];
  int           exp_shift_cyc[$];
  int           exp_done[$];
  logic [W-1:0] words[$];
  logic [W-1:0] chain[N];
  bit           m_load, m_flush;
  int           m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected none", name, act);
  endtask

  // monitor: every shift and done must match a scoreboard entry, in order and on time
  always @(negedge clk) begin
    if (!rst) begin
      if (scan_set_id) begin
        if (exp_shift.size() == 0) note_fail("unexpected_shift", 64'(scan_id_out));
        else begin
          chk("shift_word", scan_id_out, exp_shift.pop_front());
          chk("shift_cycle", cyc, exp_shift_cyc.pop_front());
        end
        for (int k = N - 1; k > 0; k--) chain[k] = chain[k-1];
        chain[0] = scan_id_out;
      end
      if (done) begin
        if (exp_done.size() == 0) note_fail("unexpected_done", 64'(cyc));
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic s, input logic a);
    bit acc, n_load, n_flush;
    id_valid = v; id_data = d; start = s; abort = a;
    #1;
    chk("busy", busy, m_load || m_flush);
    chk("id_ready", id_ready, m_load && !a);
    chk("load_cnt", load_cnt, m_cnt);
    acc     = v && m_load && !a;
    n_load  = m_load;
    n_flush = 1'b0;
    if (!m_load && !m_flush) begin
      if (s && !a) begin
        n_load = 1'b1;
        m_cnt  = 0;
        words.delete();
      end
    end else if (m_load) begin
      if (a) n_load = 1'b0;
      else if (acc) begin
        exp_shift.push_back(d);
        exp_shift_cyc.push_back(cyc + 1);
        words.push_back(d);
        m_cnt++;
        if (m_cnt == N) begin
          n_load  = 1'b0;
          n_flush = 1'b1;
          exp_done.push_back(cyc + 2);
        end
      end
    end else if (a) begin
      void'(exp_done.pop_back());
    end
    m_load  = n_load;
    m_flush = n_flush;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_full_chain();
    for (int k = 0; k < N; k++) chk("chain_node", chain[k], words[N-1-k]);
    chk("pending_shifts", exp_shift.size(), 0);
    chk("pending_done", exp_done.size(), 0);
  endtask

  initial begin
    int guard;
    logic [W-1:0] w;
    rst = 1'b1; start = 1'b0; abort = 1'b0; id_valid = 1'b0; id_data = '0;
    s1_start = 1'b0; s1_abort = 1'b0; s1_valid = 1'b0; s1_data = '0;
    m_load = 1'b0; m_flush = 1'b0; m_cnt = 0;
    for (int k = 0; k < N; k++) chain[k] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", id_ready, 0);
    chk("rst_set_id", scan_set_id, 0);
    chk("rst_id_out", scan_id_out, 0);
    chk("rst_load_cnt", load_cnt, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    // back-to-back 3,2,1,0
    step(1'b0, '0, 1'b1, 1'b0);
    for (int j = 0; j < N; j++) step(1'b1, W'(N - 1 - j), 1'b0, 1'b0);
    idle(3);
    for (int k = 0; k < N; k++) chk("b2b_node", chain[k], k);
    check_full_chain();

    // bubbles: valid pattern 1,0,0,1,1,0,1
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b0, 4'd9, 1'b0, 1'b0);
    step(1'b0, 4'd8, 1'b0, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b0, 4'd7, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0);
    idle(3);
    for (int k = 0; k < N; k++) chk("bubble_node", chain[k], k);
    chk("bubble_load_cnt", load_cnt, 4);
    check_full_chain();

    // abort after two accepts, with a word offered in the abort cycle
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b1);
    idle(3);
    chk("abort_node1", chain[1], 9);
    chk("abort_node0", chain[0], 5);
    chk("abort_load_cnt", load_cnt, 2);
    chk("abort_pending", exp_shift.size(), 0);

    // start+abort in IDLE, then start pulsed during LOAD
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 4'd12, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 4'd6, 1'b1, 1'b0);
    step(1'b1, 4'd10, 1'b0, 1'b0);
    step(1'b1, 4'd15, 1'b1, 1'b0);
    idle(3);
    check_full_chain();

    // abort during FLUSH: last shift still emitted, no done
    step(1'b0, '0, 1'b1, 1'b0);
    for (int j = 0; j < N; j++) step(1'b1, W'(j + 4), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(3);
    for (int k = 0; k < N; k++) chk("flush_abort_node", chain[k], words[N-1-k]);
    chk("flush_abort_done", exp_done.size(), 0);

    // randomized loads with bubbles and stray starts
    for (int t = 0; t < 8; t++) begin
      guard = 0;
      step(1'b0, W'($urandom), 1'b1, 1'b0);
      while (m_load && guard < 100) begin
        guard++;
        w = W'($urandom);
        if ($urandom_range(0, 3) == 0) step(1'b0, w, 1'($urandom_range(0, 1)), 1'b0);
        else step(1'b1, w, 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("rand_load_finished", m_load, 0);
      idle(3);
      check_full_chain();
    end

    // asynchronous reset mid-load
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 4'd11, 1'b0, 1'b0);
    id_valid = 1'b1; id_data = 4'd13;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", id_ready, 0);
    chk("arst_set_id", scan_set_id, 0);
    chk("arst_id_out", scan_id_out, 0);
    chk("arst_load_cnt", load_cnt, 0);
    chk("arst_done", done, 0);
    exp_shift.delete(); exp_shift_cyc.delete(); exp_done.delete();
    m_load = 1'b0; m_flush = 1'b0; m_cnt = 0;
    for (int k = 0; k < N; k++) chain[k] = '0;
    id_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    step(1'b0, '0, 1'b1, 1'b0);
    for (int j = 0; j < N; j++) step(1'b1, W'(15 - j), 1'b0, 1'b0);
    idle(3);
    check_full_chain();

    // single-node chain
    s1_start = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("n1_busy", s1_busy, 1);
    chk("n1_ready", s1_ready, 1);
    s1_start = 1'b0; s1_valid = 1'b1; s1_data = 4'd7;
    @(posedge clk); @(negedge clk); #1;
    s1_valid = 1'b0;
    chk("n1_flush_set", s1_set, 1);
    chk("n1_node0", s1_out, 7);
    chk("n1_flush_ready", s1_ready, 0);
    chk("n1_flush_done", s1_done, 0);
    chk("n1_load_cnt", s1_cnt, 1);
    @(posedge clk); @(negedge clk); #1;
    chk("n1_done", s1_done, 1);
    chk("n1_set_low", s1_set, 0);
    chk("n1_idle", s1_busy, 0);
    @(posedge clk); @(negedge clk); #1;
    chk("n1_done_pulse", s1_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
